// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock synchronous FIFO. The width and depth are parameters.
//   The occupancy count is held in its own register.
//   A read and a write can both complete in the same cycle.
//   Almost-full and almost-empty thresholds are set by parameters.
//   A rejected write or read raises a one-cycle error pulse. The pulse is not sticky.
//
// Ports
//   Clk           rising-edge clock
//   Rst           asynchronous reset, active-low
//   WR            write request; dataIn is captured when the write is accepted
//   dataIn        write data, WIDTH bits
//   RD            read request
//   dataOut       registered read data; valid one cycle after an accepted read
//   VALID         one-cycle pulse: dataOut was updated this cycle
//   EMPTY         Count == 0
//   FULL          Count == DEPTH
//   ALMOST_FULL   Count >= AF_LEVEL
//   ALMOST_EMPTY  Count <= AE_LEVEL
//   Count         occupancy, 0..DEPTH
//   OVERFLOW      one-cycle pulse: a write was rejected
//   UNDERFLOW     one-cycle pulse: a read was rejected
module fifo_sync_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WR,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             RD,
  output logic [WIDTH-1:0] dataOut,
  output logic             VALID,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic [AW:0]      Count,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_THR  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_THR  = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             wr_ok;
  logic             rd_ok;

  // The flags decode only the registered count, so they change cleanly on Clk.
  assign EMPTY        = (count_q == '0);
  assign FULL         = (count_q == DEPTH_C);
  assign ALMOST_FULL  = (count_q >= AF_THR);
  assign ALMOST_EMPTY = (count_q <= AE_THR);
  assign Count        = count_q;

  // A write into a full FIFO still proceeds when a read frees a slot in the same cycle.
  // When the FIFO is full, a read is always accepted because the FIFO is not empty.
  // The write then lands in the slot being read (wr_ptr == rd_ptr).
  // mem[rd_ptr] is sampled before the edge, so the read still returns the old word.
  assign wr_ok = WR & (~FULL | RD);
  // When the FIFO is empty there is no write-to-read bypass.
  // A write in the same cycle does not make the read succeed.
  assign rd_ok = RD & ~EMPTY;

  // Storage has no reset. After a reset the pointers and count mark every entry as stale.
  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      dataOut   <= '0;
      VALID     <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      VALID     <= rd_ok;
      OVERFLOW  <= WR & ~wr_ok;
      UNDERFLOW <= RD & ~rd_ok;

      if (wr_ok) begin
        // DEPTH is a power of two, so the pointer wraps by natural rollover.
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (rd_ok) begin
        dataOut <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end

      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic        Clk;
  logic        Rst;
  logic        WR;
  logic [31:0] dataIn;
  logic        RD;
  logic [31:0] dataOut;
  logic        VALID;
  logic        EMPTY;
  logic        FULL;
  logic        ALMOST_FULL;
  logic        ALMOST_EMPTY;
  logic [3:0]  Count;
  logic        OVERFLOW;
  logic        UNDERFLOW;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q [$];

  fifo_sync_param #(
    .WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .Clk(Clk), .Rst(Rst), .WR(WR), .dataIn(dataIn), .RD(RD),
    .dataOut(dataOut), .VALID(VALID), .EMPTY(EMPTY), .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .Count(Count),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests and return 1 ns after the rising edge.
  task automatic cyc(input logic wr, input logic rd, input logic [31:0] d);
    WR = wr; RD = rd; dataIn = d;
    @(posedge Clk);
    #1;
    WR = 1'b0; RD = 1'b0; dataIn = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt"},   Count, 0);
    chk({tag, "_empty"}, EMPTY, 1);
    chk({tag, "_full"},  FULL, 0);
    chk({tag, "_ae"},    ALMOST_EMPTY, 1);
    chk({tag, "_af"},    ALMOST_FULL, 0);
    chk({tag, "_dout"},  dataOut, 0);
    chk({tag, "_valid"}, VALID, 0);
    chk({tag, "_ovf"},   OVERFLOW, 0);
    chk({tag, "_unf"},   UNDERFLOW, 0);
  endtask

  initial begin
    Rst = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_state("rst");
    Rst = 1'b1;
    @(posedge Clk); #1;

    // Fill with 0x11..0x88 and check the flags at every occupancy level.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 32'(i * 'h11));
      chk("fill_cnt",   Count, 32'(i));
      chk("fill_af",    ALMOST_FULL, (i >= 6) ? 1 : 0);
      chk("fill_ae",    ALMOST_EMPTY, (i <= 2) ? 1 : 0);
      chk("fill_full",  FULL, (i == 8) ? 1 : 0);
      chk("fill_empty", EMPTY, 0);
      chk("fill_valid", VALID, 0);
    end

    // A write while full is rejected.
    cyc(1'b1, 1'b0, 32'h99);
    chk("ovf_pulse", OVERFLOW, 1);
    chk("ovf_cnt",   Count, 8);
    cyc(1'b0, 1'b0, 32'h0);
    chk("ovf_clear", OVERFLOW, 0);
    chk("ovf_cnt2",  Count, 8);

    // Drain the FIFO. The 0x99 write must not appear.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      chk("drain_dout",  dataOut, 32'(i * 'h11));
      chk("drain_valid", VALID, 1);
      chk("drain_cnt",   Count, 32'(8 - i));
    end
    chk("drain_empty", EMPTY, 1);
    cyc(1'b0, 1'b1, 32'h0);
    chk("unf_pulse", UNDERFLOW, 1);
    chk("unf_valid", VALID, 0);
    chk("unf_hold",  dataOut, 32'h88);
    chk("unf_cnt",   Count, 0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("unf_clear", UNDERFLOW, 0);

    // Simultaneous read and write while full.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 32'(i * 'h11));
    chk("refill_full", FULL, 1);
    cyc(1'b1, 1'b1, 32'hAA);
    chk("fullrw_dout",  dataOut, 32'h11);
    chk("fullrw_valid", VALID, 1);
    chk("fullrw_cnt",   Count, 8);
    chk("fullrw_ovf",   OVERFLOW, 0);
    for (int i = 2; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      chk("fullrw_drain", dataOut, 32'(i * 'h11));
    end
    cyc(1'b0, 1'b1, 32'h0);
    chk("fullrw_last", dataOut, 32'hAA);
    chk("fullrw_empty", EMPTY, 1);

    // Simultaneous read and write while empty: no bypass.
    cyc(1'b1, 1'b1, 32'h5);
    chk("emptyrw_unf",   UNDERFLOW, 1);
    chk("emptyrw_valid", VALID, 0);
    chk("emptyrw_cnt",   Count, 1);
    cyc(1'b0, 1'b1, 32'h0);
    chk("emptyrw_dout",  dataOut, 32'h5);
    chk("emptyrw_valid2", VALID, 1);
    chk("emptyrw_cnt2",  Count, 0);

    // Interleaved traffic across pointer wrap, checked against a queue model.
    q.delete();
    for (int k = 0; k < 20; k++) begin
      logic wr, rd, exp_rd, exp_wr;
      logic [31:0] d, e;
      wr = (k % 3 != 2);
      rd = (k % 3 != 0);
      d  = 32'h100 + 32'(k);
      e  = '0;
      exp_rd = rd && (q.size() > 0);
      exp_wr = wr && ((q.size() < 8) || rd);
      if (exp_rd) e = q.pop_front();
      if (exp_wr) q.push_back(d);
      cyc(wr, rd, d);
      chk("mix_valid", VALID, 32'(exp_rd));
      if (exp_rd) chk("mix_dout", dataOut, e);
      chk("mix_cnt", Count, 32'(q.size()));
      chk("mix_ovf", OVERFLOW, 32'(wr && !exp_wr));
      chk("mix_unf", UNDERFLOW, 32'(rd && !exp_rd));
    end

    // Bring the occupancy to 3, then reset mid-stream.
    while (q.size() < 3) begin
      q.push_back(32'h200 + 32'(q.size()));
      cyc(1'b1, 1'b0, q[q.size()-1]);
    end
    chk("pre_rst_cnt", Count, 3);
    Rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge Clk); #1;
    Rst = 1'b1;
    q.delete();
    cyc(1'b0, 1'b1, 32'h0);
    chk("post_rst_unf", UNDERFLOW, 1);
    chk("post_rst_cnt", Count, 0);
    chk("post_rst_dout", dataOut, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
